sme_job_sequencer: RTL and testbench

Front-end controller for the string-matching engine (SME). A host preloads one target string and a queue of up to MAX_PAT patterns, then pulses go. The block streams the bytes serially into the engine's chardata/isstring/ispattern interface, one pattern job at a time, and waits for each result. It returns per-pattern results tagged with a pattern id, with timeout protection.

---
 rtl/sme_job_sequencer.sv | 224 ++++++++++++++++++++++
 tb/tb_sme_job_sequencer.sv | 379 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sme_job_sequencer.sv
// Host-side job sequencer for the string-matching engine: buffers one string and a
// queue of patterns, streams them serially to the engine and returns tagged results.
module sme_job_sequencer #(
    parameter int STR_MAX = 32,
    parameter int PAT_MAX = 9,
    parameter int MAX_PAT = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [7:0]                 host_char,
    input  logic                       host_str_wr,
    input  logic                       host_pat_wr,
    input  logic                       host_pat_end,
    input  logic                       host_go,
    output logic                       busy,
    output logic [7:0]                 chardata,
    output logic                       isstring,
    output logic                       ispattern,
    input  logic                       sme_valid,
    input  logic                       sme_match,
    input  logic [$clog2(STR_MAX)-1:0] sme_match_index,
    output logic                       res_valid,
    output logic [$clog2(MAX_PAT)-1:0] res_pat_id,
    output logic                       res_match,
    output logic [$clog2(STR_MAX)-1:0] res_index,
    output logic                       res_timeout,
    output logic                       done,
    output logic                       err_overflow
);
    localparam int SLW = $clog2(STR_MAX + 1);
    localparam int SAW = $clog2(STR_MAX);
    localparam int PLW = $clog2(PAT_MAX + 1);
    localparam int PAW = $clog2(PAT_MAX);
    localparam int PCW = $clog2(MAX_PAT + 1);
    localparam int IDW = $clog2(MAX_PAT);
    localparam int TCW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {S_IDLE, S_SEND_STR, S_SEND_PAT, S_WAIT, S_RESULT, S_FIN} state_t;

    state_t         r_state, w_state_nx;
    logic [SLW-1:0] r_idx, w_idx_nx;
    logic [IDW-1:0] r_job, w_job_nx;
    logic [TCW-1:0] r_cnt, w_cnt_nx;
    logic [7:0]     r_str_mem [STR_MAX];
    logic [7:0]     r_pat_mem [MAX_PAT][PAT_MAX];
    logic [SLW-1:0] r_str_len;
    logic [PCW-1:0] r_pat_cnt;
    logic [PLW-1:0] r_pat_len [MAX_PAT];
    logic           r_err, r_busy, r_done;
    logic           r_isstr, r_ispat, r_rv, r_rto, r_rm;
    logic [7:0]     r_char;
    logic [SAW-1:0] r_ri;
    logic [IDW-1:0] r_rid;
    logic           w_isstr_nx, w_ispat_nx, w_rv_nx, w_rto_nx, w_rm_nx;
    logic [7:0]     w_char_nx;
    logic [SAW-1:0] w_ri_nx;
    logic [PLW-1:0] w_cur_len;

    // Host load path; go wins over a same-cycle write.
    logic           w_load, w_str_we, w_pat_room, w_pat_acc, w_pat_we, w_drop;
    logic [IDW-1:0] w_wr_slot;
    logic [PLW-1:0] w_wr_len;

    assign w_load     = (r_state == S_IDLE) && !host_go;
    assign w_wr_slot  = r_pat_cnt[IDW-1:0];
    assign w_wr_len   = r_pat_len[w_wr_slot];
    assign w_str_we   = w_load && host_str_wr && (r_str_len < SLW'(STR_MAX));
    assign w_pat_room = r_pat_cnt < PCW'(MAX_PAT);
    assign w_pat_acc  = w_load && host_pat_wr && !host_str_wr && w_pat_room;
    assign w_pat_we   = w_pat_acc && (w_wr_len < PLW'(PAT_MAX));
    assign w_drop     = w_load && ((host_str_wr && !w_str_we) || (host_pat_wr && !w_pat_we));
    assign w_cur_len  = r_pat_len[r_job];

    always_ff @(posedge clk) begin
        if (w_str_we) r_str_mem[r_str_len[SAW-1:0]] <= host_char;
        if (w_pat_we) r_pat_mem[w_wr_slot][w_wr_len[PAW-1:0]] <= host_char;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_str_len <= '0;
            r_pat_cnt <= '0;
            r_err     <= 1'b0;
            for (int i = 0; i < MAX_PAT; i++) r_pat_len[i] <= '0;
        end else begin
            if (w_str_we) r_str_len <= r_str_len + SLW'(1);
            if (w_pat_we) r_pat_len[w_wr_slot] <= w_wr_len + PLW'(1);
            // An overflowing byte still closes its pattern when flagged as the end.
            if (w_pat_acc && host_pat_end) r_pat_cnt <= r_pat_cnt + PCW'(1);
            if (r_state == S_IDLE && host_go) r_err <= 1'b0;
            else if (w_drop)                  r_err <= 1'b1;
            if (r_state == S_FIN) begin
                r_pat_cnt <= '0;
                for (int i = 0; i < MAX_PAT; i++) r_pat_len[i] <= '0;
            end
        end
    end

    // Next-state logic also computes the next registered engine/result outputs.
    always_comb begin
        w_state_nx = r_state;
        w_idx_nx   = r_idx;
        w_job_nx   = r_job;
        w_cnt_nx   = r_cnt;
        w_isstr_nx = 1'b0;
        w_ispat_nx = 1'b0;
        w_char_nx  = '0;
        w_rv_nx    = 1'b0;
        w_rto_nx   = 1'b0;
        w_rm_nx    = 1'b0;
        w_ri_nx    = '0;
        case (r_state)
            S_IDLE: if (host_go) begin
                if (r_str_len == '0 || r_pat_cnt == '0) begin
                    w_state_nx = S_FIN;
                end else begin
                    w_state_nx = S_SEND_STR;
                    w_idx_nx   = '0;
                    w_job_nx   = '0;
                    w_isstr_nx = 1'b1;
                    w_char_nx  = r_str_mem[0];
                end
            end
            S_SEND_STR: begin
                if (r_idx == r_str_len - SLW'(1)) begin
                    w_state_nx = S_SEND_PAT;
                    w_idx_nx   = '0;
                    w_ispat_nx = 1'b1;
                    w_char_nx  = r_pat_mem[r_job][0];
                end else begin
                    w_idx_nx   = r_idx + SLW'(1);
                    w_isstr_nx = 1'b1;
                    w_char_nx  = r_str_mem[w_idx_nx[SAW-1:0]];
                end
            end
            S_SEND_PAT: begin
                if (r_idx == SLW'(w_cur_len) - SLW'(1)) begin
                    w_state_nx = S_WAIT;
                    w_cnt_nx   = '0;
                end else begin
                    w_idx_nx   = r_idx + SLW'(1);
                    w_ispat_nx = 1'b1;
                    w_char_nx  = r_pat_mem[r_job][w_idx_nx[PAW-1:0]];
                end
            end
            S_WAIT: begin
                if (sme_valid) begin
                    w_state_nx = S_RESULT;
                    w_rv_nx    = 1'b1;
                    w_rm_nx    = sme_match;
                    w_ri_nx    = sme_match ? sme_match_index : '0;
                end else if (r_cnt == TCW'(TIMEOUT - 1)) begin
                    w_state_nx = S_RESULT;
                    w_rv_nx    = 1'b1;
                    w_rto_nx   = 1'b1;
                end else begin
                    w_cnt_nx   = r_cnt + TCW'(1);
                end
            end
            S_RESULT: begin
                // The engine keeps its string, so later jobs send only the pattern.
                if (!r_rto && (PCW'(r_job) + PCW'(1) < r_pat_cnt)) begin
                    w_state_nx = S_SEND_PAT;
                    w_job_nx   = r_job + IDW'(1);
                    w_idx_nx   = '0;
                    w_ispat_nx = 1'b1;
                    w_char_nx  = r_pat_mem[r_job + IDW'(1)][0];
                end else begin
                    w_state_nx = S_FIN;
                end
            end
            S_FIN:   w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_job   <= '0;
            r_cnt   <= '0;
            r_isstr <= 1'b0;
            r_ispat <= 1'b0;
            r_char  <= '0;
            r_rv    <= 1'b0;
            r_rto   <= 1'b0;
            r_rm    <= 1'b0;
            r_ri    <= '0;
            r_rid   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_idx   <= w_idx_nx;
            r_job   <= w_job_nx;
            r_cnt   <= w_cnt_nx;
            r_isstr <= w_isstr_nx;
            r_ispat <= w_ispat_nx;
            r_char  <= w_char_nx;
            r_rv    <= w_rv_nx;
            r_rto   <= w_rto_nx;
            r_rm    <= w_rm_nx;
            r_ri    <= w_ri_nx;
            r_rid   <= w_rv_nx ? r_job : '0;
            r_busy  <= (w_state_nx == S_SEND_STR) || (w_state_nx == S_SEND_PAT) ||
                       (w_state_nx == S_WAIT)     || (w_state_nx == S_RESULT);
            r_done  <= (r_state == S_FIN);
        end
    end

    assign busy         = r_busy;
    assign chardata     = r_char;
    assign isstring     = r_isstr;
    assign ispattern    = r_ispat;
    assign res_valid    = r_rv;
    assign res_pat_id   = r_rid;
    assign res_match    = r_rm;
    assign res_index    = r_ri;
    assign res_timeout  = r_rto;
    assign done         = r_done;
    assign err_overflow = r_err;
endmodule

// File: tb/tb_sme_job_sequencer.sv
// Bench for sme_job_sequencer: acts as host and engine; a monitor scoreboards the
// streamed bytes and the tagged results against queues filled as stimulus is set up.
module tb_sme_job_sequencer;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] host_char = '0;
    logic       host_str_wr = 1'b0, host_pat_wr = 1'b0, host_pat_end = 1'b0, host_go = 1'b0;
    logic       busy, isstring, ispattern, res_valid, res_match, res_timeout, done, err_overflow;
    logic [7:0] chardata;
    logic       sme_valid = 1'b0, sme_match = 1'b0;
    logic [4:0] sme_match_index = '0;
    logic [2:0] res_pat_id;
    logic [4:0] res_index;

    int n_checks = 0;
    int n_fail   = 0;

    logic [8:0] exp_q[$];   // {is_string, byte}
    logic [9:0] res_q[$];   // {timeout, match, index[4:0], id[2:0]}

    sme_job_sequencer #(.STR_MAX(32), .PAT_MAX(9), .MAX_PAT(8), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .host_char(host_char), .host_str_wr(host_str_wr),
        .host_pat_wr(host_pat_wr), .host_pat_end(host_pat_end), .host_go(host_go),
        .busy(busy), .chardata(chardata), .isstring(isstring), .ispattern(ispattern),
        .sme_valid(sme_valid), .sme_match(sme_match), .sme_match_index(sme_match_index),
        .res_valid(res_valid), .res_pat_id(res_pat_id), .res_match(res_match),
        .res_index(res_index), .res_timeout(res_timeout), .done(done),
        .err_overflow(err_overflow));

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Scoreboard monitor, sampling on the falling edge.
    always @(negedge clk) begin
        logic [8:0] e;
        logic [9:0] r;
        if (isstring || ispattern) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL stream_extra: got str=%0b pat=%0b byte=%h, none expected",
                         isstring, ispattern, chardata);
            end else begin
                e = exp_q.pop_front();
                if ({isstring, ispattern, chardata} !== {e[8], ~e[8], e[7:0]}) begin
                    n_fail++;
                    $display("FAIL stream_byte: got str=%0b pat=%0b byte=%h, want str=%0b byte=%h",
                             isstring, ispattern, chardata, e[8], e[7:0]);
                end
            end
        end else begin
            n_checks++;
            if (chardata !== 8'h00) begin
                n_fail++;
                $display("FAIL idle_chardata: got %h want 00", chardata);
            end
        end
        if (res_valid) begin
            n_checks++;
            if (res_q.size() == 0) begin
                n_fail++;
                $display("FAIL result_extra: got id=%0d m=%0b idx=%0d to=%0b, none expected",
                         res_pat_id, res_match, res_index, res_timeout);
            end else begin
                r = res_q.pop_front();
                if ({res_timeout, res_match, res_index, res_pat_id} !== r) begin
                    n_fail++;
                    $display("FAIL result: got to=%0b m=%0b idx=%0d id=%0d, want to=%0b m=%0b idx=%0d id=%0d",
                             res_timeout, res_match, res_index, res_pat_id,
                             r[9], r[8], r[7:3], r[2:0]);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wr_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            host_char = s[i]; host_str_wr = 1'b1;
            tick();
        end
        host_str_wr = 1'b0;
    endtask

    task automatic wr_pat(input string s);
        for (int i = 0; i < s.len(); i++) begin
            host_char = s[i]; host_pat_wr = 1'b1; host_pat_end = (i == s.len() - 1);
            tick();
        end
        host_pat_wr = 1'b0; host_pat_end = 1'b0;
    endtask

    task automatic push_bytes(input string s, input int n, input bit is_str);
        for (int i = 0; i < n; i++) exp_q.push_back({is_str, s[i]});
    endtask

    task automatic go_pulse;
        host_go = 1'b1;
        tick();
        host_go = 1'b0;
    endtask

    // Returns in the first cycle after the pattern stream ends (the WAIT state).
    task automatic wait_wait_entry(output bit ok);
        bit seen = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (ispattern) seen = 1'b1;
            else if (seen) begin ok = 1'b1; break; end
            tick();
        end
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL wait_entry: pattern stream end not seen within 200 cycles");
        end
    endtask

    task automatic engine_reply(input logic m, input logic [4:0] idx);
        bit ok;
        wait_wait_entry(ok);
        sme_valid = 1'b1; sme_match = m; sme_match_index = idx;
        tick();
        sme_valid = 1'b0; sme_match = 1'b0; sme_match_index = '0;
        n_checks++;
        if (res_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL result_latency: res_valid=%b one cycle after sme_valid, want 1", res_valid);
        end
    endtask

    task automatic wait_done(input int bound);
        bit seen = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (done === 1'b1) begin seen = 1'b1; break; end
            tick();
        end
        n_checks++;
        if (!seen) begin
            n_fail++;
            $display("FAIL done_wait: done not seen within %0d cycles", bound);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL done_busy: busy=%b at done, want 0", busy);
        end
        tick();
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL done_pulse: done=%b a cycle later, want 0", done);
        end
    endtask

    task automatic check_drained(input string name);
        n_checks++;
        if (exp_q.size() != 0 || res_q.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drained: %0d bytes and %0d results left, want 0 and 0",
                     name, exp_q.size(), res_q.size());
            exp_q.delete();
            res_q.delete();
        end
    endtask

    task automatic test_reset;
        do_reset();
        n_checks++;
        if ({busy, isstring, ispattern, chardata} !== 11'h0) begin
            n_fail++;
            $display("FAIL reset_stream: busy=%b str=%b pat=%b char=%h, want all 0",
                     busy, isstring, ispattern, chardata);
        end
        n_checks++;
        if ({res_valid, res_match, res_index, res_pat_id, res_timeout} !== 11'h0) begin
            n_fail++;
            $display("FAIL reset_result: v=%b m=%b idx=%0d id=%0d to=%b, want all 0",
                     res_valid, res_match, res_index, res_pat_id, res_timeout);
        end
        n_checks++;
        if ({done, err_overflow} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_flags: done=%b err=%b, want 0 0", done, err_overflow);
        end
    endtask

    task automatic test_single;
        wr_str("hello world");
        wr_pat("wor");
        push_bytes("hello world", 11, 1'b1);
        push_bytes("wor", 3, 1'b0);
        res_q.push_back({1'b0, 1'b1, 5'd6, 3'd0});
        go_pulse();
        n_checks++;
        if ({busy, isstring, chardata} !== {1'b1, 1'b1, 8'h68}) begin
            n_fail++;
            $display("FAIL go_latency: busy=%b str=%b char=%h, want 1 1 68", busy, isstring, chardata);
        end
        engine_reply(1'b1, 5'd6);
        wait_done(5);
        check_drained("single");
    endtask

    task automatic test_two_patterns;
        wr_pat("^hel");
        wr_pat("xyz");
        push_bytes("hello world", 11, 1'b1);
        push_bytes("^hel", 4, 1'b0);
        push_bytes("xyz", 3, 1'b0);
        res_q.push_back({1'b0, 1'b1, 5'd0, 3'd0});
        res_q.push_back({1'b0, 1'b0, 5'd0, 3'd1});
        go_pulse();
        engine_reply(1'b1, 5'd0);
        engine_reply(1'b0, 5'd7);
        wait_done(5);
        check_drained("two_pat");
    endtask

    task automatic test_empty_go;
        go_pulse();
        n_checks++;
        if ({busy, done} !== 2'b00) begin
            n_fail++;
            $display("FAIL empty_go_c1: busy=%b done=%b, want 0 0", busy, done);
        end
        tick();
        n_checks++;
        if ({busy, done} !== 2'b01) begin
            n_fail++;
            $display("FAIL empty_go_c2: busy=%b done=%b, want 0 1", busy, done);
        end
        tick();
        n_checks++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL empty_go_c3: done=%b, want 0", done);
        end
        check_drained("empty");
    endtask

    task automatic test_overflow;
        string s32 = "";
        for (int i = 0; i < 32; i++) s32 = $sformatf("%s%c", s32, 8'(65 + i));
        do_reset();
        for (int i = 0; i < 31; i++) begin
            host_char = s32[i]; host_str_wr = 1'b1;
            tick();
        end
        n_checks++;
        if (err_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clean: err=%b after 31 bytes, want 0", err_overflow);
        end
        host_char = s32[31]; host_str_wr = 1'b1; host_pat_wr = 1'b1;
        tick();
        host_pat_wr = 1'b0;
        n_checks++;
        if (err_overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_collision: err=%b after str+pat write, want 1", err_overflow);
        end
        host_char = "!";
        tick();
        host_str_wr = 1'b0;
        wr_pat("0123456789");
        push_bytes(s32, 32, 1'b1);
        push_bytes("0123456789", 9, 1'b0);
        res_q.push_back({1'b0, 1'b1, 5'd3, 3'd0});
        go_pulse();
        n_checks++;
        if (err_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clear: err=%b after go, want 0", err_overflow);
        end
        engine_reply(1'b1, 5'd3);
        wait_done(5);
        check_drained("overflow");
    endtask

    task automatic test_timeout;
        bit ok;
        int k = 0;
        string s32 = "";
        for (int i = 0; i < 32; i++) s32 = $sformatf("%s%c", s32, 8'(65 + i));
        wr_pat("ab");
        wr_pat("cd");
        wr_pat("ef");
        push_bytes(s32, 32, 1'b1);
        push_bytes("ab", 2, 1'b0);
        res_q.push_back({1'b1, 1'b0, 5'd0, 3'd0});
        go_pulse();
        wait_wait_entry(ok);
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (res_valid === 1'b1) begin k = i; break; end
        end
        n_checks++;
        if (k != 16 || res_timeout !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_latency: res_valid after %0d cycles to=%b, want 16 and 1", k, res_timeout);
        end
        wait_done(5);
        for (int i = 0; i < 10; i++) tick();
        check_drained("timeout");
    endtask

    task automatic test_reset_midrun;
        do_reset();
        wr_str("ab");
        wr_pat("cdef");
        push_bytes("ab", 2, 1'b1);
        push_bytes("cd", 2, 1'b0);
        go_pulse();
        tick();
        tick();
        tick();
        n_checks++;
        if ({ispattern, chardata} !== {1'b1, 8'h64}) begin
            n_fail++;
            $display("FAIL midrun_pos: pat=%b char=%h, want 1 64", ispattern, chardata);
        end
        reset = 1'b1;
        tick();
        n_checks++;
        if ({isstring, ispattern, busy, done, res_valid} !== 5'b0) begin
            n_fail++;
            $display("FAIL midrun_reset: str=%b pat=%b busy=%b done=%b rv=%b, want all 0",
                     isstring, ispattern, busy, done, res_valid);
        end
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_checks++;
            if ({done, res_valid, busy} !== 3'b000) begin
                n_fail++;
                $display("FAIL midrun_quiet: done=%b rv=%b busy=%b, want 0 0 0", done, res_valid, busy);
            end
        end
        check_drained("midrun");
        wr_str("xy");
        wr_pat("z");
        push_bytes("xy", 2, 1'b1);
        push_bytes("z", 1, 1'b0);
        res_q.push_back({1'b0, 1'b1, 5'd1, 3'd0});
        go_pulse();
        engine_reply(1'b1, 5'd1);
        wait_done(5);
        check_drained("rerun");
    endtask

    initial begin
        test_reset();
        test_single();
        test_two_patterns();
        test_empty_go();
        test_overflow();
        test_timeout();
        test_reset_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
